// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with burst-limited ownership and a one-cycle load return path.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking from IDLE; the default is fixed priority to port 0.
module dmem_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_gnt,
    output logic        r0_rvalid,
    output logic [31:0] r0_rdata,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_gnt,
    output logic        r1_rvalid,
    output logic [31:0] r1_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN0,
        ST_OWN1
    } state_t;

    localparam logic [3:0] MAXC = 4'(MAX_BURST);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_count;
    logic [3:0] w_count_nxt;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_tie_win;
    logic       r_pend_vld;
    logic       r_pend_port;

`ifdef DMEM_ARB_RR_EN
    logic r_last;

    always_comb begin
        w_tie_win = ~r_last;
    end
`else
    always_comb begin
        w_tie_win = 1'b0;
    end
`endif

    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            ST_IDLE: begin
                if (r0_req && r1_req) begin
                    w_gnt0      = ~w_tie_win;
                    w_gnt1      = w_tie_win;
                    w_state_nxt = w_tie_win ? ST_OWN1 : ST_OWN0;
                    w_count_nxt = 4'd1;
                end else if (r0_req) begin
                    w_gnt0      = 1'b1;
                    w_state_nxt = ST_OWN0;
                    w_count_nxt = 4'd1;
                end else if (r1_req) begin
                    w_gnt1      = 1'b1;
                    w_state_nxt = ST_OWN1;
                    w_count_nxt = 4'd1;
                end else begin
                    w_count_nxt = '0;
                end
            end
            ST_OWN0: begin
                if (r0_req) begin
                    if (r_count < MAXC) begin
                        w_gnt0      = 1'b1;
                        w_count_nxt = r_count + 4'd1;
                    end else if (r1_req) begin
                        w_gnt1      = 1'b1;
                        w_state_nxt = ST_OWN1;
                        w_count_nxt = 4'd1;
                    end else begin
                        // Burst limit reached with no contender: restart the count.
                        w_gnt0      = 1'b1;
                        w_count_nxt = 4'd1;
                    end
                end else if (r1_req) begin
                    w_gnt1      = 1'b1;
                    w_state_nxt = ST_OWN1;
                    w_count_nxt = 4'd1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end
            end
            ST_OWN1: begin
                if (r1_req) begin
                    if (r_count < MAXC) begin
                        w_gnt1      = 1'b1;
                        w_count_nxt = r_count + 4'd1;
                    end else if (r0_req) begin
                        w_gnt0      = 1'b1;
                        w_state_nxt = ST_OWN0;
                        w_count_nxt = 4'd1;
                    end else begin
                        w_gnt1      = 1'b1;
                        w_count_nxt = 4'd1;
                    end
                end else if (r0_req) begin
                    w_gnt0      = 1'b1;
                    w_state_nxt = ST_OWN0;
                    w_count_nxt = 4'd1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
            end
        endcase
        if (!rst) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_port <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_pend_vld  <= (w_gnt0 & ~r0_we) | (w_gnt1 & ~r1_we);
            r_pend_port <= w_gnt1;
        end
    end

`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last <= 1'b1;
        end else if (w_gnt0 || w_gnt1) begin
            r_last <= w_gnt1;
        end
    end
`endif

    always_comb begin
        r0_gnt    = w_gnt0;
        r1_gnt    = w_gnt1;
        mem_en    = w_gnt0 | w_gnt1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_gnt0) begin
            mem_we    = r0_we;
            mem_addr  = r0_addr;
            mem_wdata = r0_wdata;
        end else if (w_gnt1) begin
            mem_we    = r1_we;
            mem_addr  = r1_addr;
            mem_wdata = r1_wdata;
        end
        // Return path is masked while reset is held so an in-flight load never surfaces.
        r0_rvalid = rst & r_pend_vld & ~r_pend_port;
        r1_rvalid = rst & r_pend_vld & r_pend_port;
        r0_rdata  = r0_rvalid ? mem_rdata : '0;
        r1_rdata  = r1_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (MAX_BURST=4); memory returns addr ^ 32'h5A5A0000.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [31:0] r0_rdata, r1_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= mem_addr ^ 32'h5A5A_0000;
    end

    // Advance one cycle; inputs change and outputs are sampled away from the rising edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
        r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        r0_req = 1'b1; r1_req = 1'b1; r1_we = 1'b1;
        @(negedge clk); #1;
        tick();
        checks++;
        if ({r0_gnt, r1_gnt, mem_en, mem_we} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes got %b want 0000", {r0_gnt, r1_gnt, mem_en, mem_we});
        end
        checks++;
        if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_rvalid got %b want 00", {r0_rvalid, r1_rvalid});
        end
        checks++;
        if (mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_addr got %h want 00000000", mem_addr);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_single_load();
        rst = 1'b1;
        r0_req = 1'b1; r0_addr = 32'h10;
        #1;
        checks++;
        if ({r0_gnt, r1_gnt, mem_en, mem_we} !== 4'b1010) begin
            errors++;
            $display("FAIL load_grant got %b want 1010", {r0_gnt, r1_gnt, mem_en, mem_we});
        end
        checks++;
        if (mem_addr !== 32'h10) begin
            errors++;
            $display("FAIL load_addr got %h want 00000010", mem_addr);
        end
        tick();
        r0_req = 1'b0; r0_addr = '0;
        #1;
        checks++;
        if ({r0_rvalid, r1_rvalid} !== 2'b10 || r0_rdata !== 32'h5A5A_0010 || r1_rdata !== 32'h0) begin
            errors++;
            $display("FAIL load_return got v=%b d0=%h d1=%h want v=10 d0=5a5a0010 d1=0",
                     {r0_rvalid, r1_rvalid}, r0_rdata, r1_rdata);
        end
        tick();
        checks++;
        if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL load_single_pulse got %b want 00", {r0_rvalid, r1_rvalid});
        end
    endtask

    task automatic test_store();
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'h20; r1_wdata = 32'hA5;
        #1;
        checks++;
        if ({r0_gnt, r1_gnt, mem_en, mem_we} !== 4'b0111 || mem_addr !== 32'h20 || mem_wdata !== 32'hA5) begin
            errors++;
            $display("FAIL store_grant got g=%b a=%h d=%h want g=0111 a=00000020 d=000000a5",
                     {r0_gnt, r1_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL store_no_rvalid got %b want 00", {r0_rvalid, r1_rvalid});
        end
        tick();
    endtask

    task automatic test_burst();
        int exp_port [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
        r0_req = 1'b1; r0_addr = 32'h100;
        r1_req = 1'b1; r1_addr = 32'h200;
        #1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({r0_gnt, r1_gnt} !== (exp_port[i] == 1 ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL burst_grant[%0d] got %b want port %0d", i, {r0_gnt, r1_gnt}, exp_port[i]);
            end
            if (i > 0) begin
                checks++;
                if (exp_port[i-1] == 0 ? (r0_rvalid !== 1'b1 || r0_rdata !== 32'h5A5A_0100 || r1_rvalid !== 1'b0)
                                       : (r1_rvalid !== 1'b1 || r1_rdata !== 32'h5A5A_0200 || r0_rvalid !== 1'b0)) begin
                    errors++;
                    $display("FAIL burst_return[%0d] got v=%b d0=%h d1=%h want port %0d",
                             i, {r0_rvalid, r1_rvalid}, r0_rdata, r1_rdata, exp_port[i-1]);
                end
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_alternate();
        logic [31:0] addrs [4] = '{32'h40, 32'h44, 32'h48, 32'h4C};
        logic [31:0] exp_d [4] = '{32'h5A5A_0040, 32'h5A5A_0044, 32'h5A5A_0048, 32'h5A5A_004C};
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            if (i < 4) begin
                if (i % 2 == 0) begin r0_req = 1'b1; r0_addr = addrs[i]; end
                else begin r1_req = 1'b1; r1_addr = addrs[i]; end
            end
            #1;
            if (i < 4) begin
                checks++;
                if ({r0_gnt, r1_gnt} !== (i % 2 == 0 ? 2'b10 : 2'b01) || mem_addr !== addrs[i]) begin
                    errors++;
                    $display("FAIL alt_grant[%0d] got g=%b a=%h want a=%h", i, {r0_gnt, r1_gnt}, mem_addr, addrs[i]);
                end
            end
            if (i > 0) begin
                checks++;
                if ((i - 1) % 2 == 0 ? ({r0_rvalid, r1_rvalid} !== 2'b10 || r0_rdata !== exp_d[i-1] || r1_rdata !== 32'h0)
                                     : ({r0_rvalid, r1_rvalid} !== 2'b01 || r1_rdata !== exp_d[i-1] || r0_rdata !== 32'h0)) begin
                    errors++;
                    $display("FAIL alt_return[%0d] got v=%b d0=%h d1=%h want data %h",
                             i, {r0_rvalid, r1_rvalid}, r0_rdata, r1_rdata, exp_d[i-1]);
                end
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_saturate();
        int exp_port [3] = '{0, 0, 1};
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'h300;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if ({r0_gnt, r1_gnt} !== 2'b10) begin
                errors++;
                $display("FAIL sat_grant[%0d] got %b want 10", i, {r0_gnt, r1_gnt});
            end
            tick();
        end
        // After the restart the count is 2, so port 0 keeps two more grants before yielding.
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'h304;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({r0_gnt, r1_gnt} !== (exp_port[i] == 1 ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL sat_contend[%0d] got %b want port %0d", i, {r0_gnt, r1_gnt}, exp_port[i]);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        int exp_port [5] = '{0, 0, 0, 0, 1};
        r1_req = 1'b1; r1_addr = 32'h400;
        tick();
        tick();
        idle_inputs();
        r0_req = 1'b1; r0_addr = 32'h410;
        #1;
        checks++;
        if ({r0_gnt, r1_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_pre_grant got %b want 10", {r0_gnt, r1_gnt});
        end
        tick();
        rst = 1'b0;
        r1_req = 1'b1;
        #1;
        checks++;
        if ({r0_rvalid, r1_rvalid, r0_gnt, r1_gnt, mem_en} !== 5'b00000) begin
            errors++;
            $display("FAIL rstmid_masked got %b want 00000", {r0_rvalid, r1_rvalid, r0_gnt, r1_gnt, mem_en});
        end
        tick();
        checks++;
        if ({r0_rvalid, r1_rvalid, r0_gnt, r1_gnt, mem_en} !== 5'b00000) begin
            errors++;
            $display("FAIL rstmid_held got %b want 00000", {r0_rvalid, r1_rvalid, r0_gnt, r1_gnt, mem_en});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_no_stale got %b want 00", {r0_rvalid, r1_rvalid});
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({r0_gnt, r1_gnt} !== (exp_port[i] == 1 ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL rstmid_idle_seq[%0d] got %b want port %0d", i, {r0_gnt, r1_gnt}, exp_port[i]);
            end
            tick();
            #1;
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        test_reset();
        test_single_load();
        test_store();
        test_burst();
        test_alternate();
        test_saturate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
